// File: rtl/clkdiv_ctrl.sv
// Runtime tick-divider controller: divisor shadowing applied on period boundaries, burst/free-run sequencing.
// Optional feature macro CLKDIV_CTRL_TICK_CNT_EN adds a saturating 32-bit tick_count output.
module clkdiv_ctrl #(
  parameter int CNT_WIDTH   = 16,
  parameter int DEF_DIV     = 5208,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CNT_WIDTH-1:0]   cfg_div,
  input  logic [BURST_WIDTH-1:0] cfg_burst,
  input  logic                   start,
  input  logic                   stop,
  output logic                   busy,
  output logic                   tick,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   div_cur
`ifdef CLKDIV_CTRL_TICK_CNT_EN
  ,
  output logic [31:0]            tick_count
`endif
);

  localparam logic [CNT_WIDTH-1:0]   DIV_RST    = CNT_WIDTH'(DEF_DIV);
  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] BURST_ZERO = {BURST_WIDTH{1'b0}};
  localparam logic [BURST_WIDTH-1:0] BURST_ONE  = BURST_WIDTH'(1);

  // FINISH holds busy for the cycle that carries the final tick/done.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] clamp_div(input logic [CNT_WIDTH-1:0] d);
    clamp_div = (d == CNT_ZERO) ? CNT_ONE : d;
  endfunction

  state_t                 state_r, state_s;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
  logic [CNT_WIDTH-1:0]   div_r, div_s;
  logic [BURST_WIDTH-1:0] burst_r, burst_s;
  logic [BURST_WIDTH-1:0] remain_r, remain_s;
  logic                   shd_full_r, shd_full_s;
  logic [CNT_WIDTH-1:0]   shd_div_r, shd_div_s;
  logic [BURST_WIDTH-1:0] shd_burst_r, shd_burst_s;
  logic                   tick_r, tick_s;
  logic                   done_r, done_s;
  logic                   busy_r;
  logic                   ready_r;
  logic                   accept_s, period_end_s;
  logic                   apply_shd_s, load_cfg_s, fill_shd_s;

  // Next-state, counter and configuration-path decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    div_s        = div_r;
    burst_s      = burst_r;
    remain_s     = remain_r;
    shd_full_s   = shd_full_r;
    shd_div_s    = shd_div_r;
    shd_burst_s  = shd_burst_r;
    tick_s       = 1'b0;
    done_s       = 1'b0;
    apply_shd_s  = 1'b0;
    load_cfg_s   = 1'b0;
    fill_shd_s   = 1'b0;
    accept_s     = cfg_valid && ready_r;
    period_end_s = (cnt_r == (div_r - CNT_ONE));

    case (state_r)
      ST_IDLE: begin
        cnt_s      = CNT_ZERO;
        load_cfg_s = accept_s;
        if (start) begin
          state_s  = ST_RUN;
          remain_s = burst_r;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (period_end_s) begin
          tick_s      = 1'b1;
          cnt_s       = CNT_ZERO;
          remain_s    = remain_r - BURST_ONE;
          apply_shd_s = shd_full_r;
          fill_shd_s  = accept_s;
          if ((burst_r != BURST_ZERO) && (remain_r == BURST_ONE)) begin
            done_s  = 1'b1;
            state_s = ST_FINISH;
          end else if (stop) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RUN;
          end
        end else if (stop) begin
          state_s     = ST_IDLE;
          cnt_s       = CNT_ZERO;
          apply_shd_s = shd_full_r;
          load_cfg_s  = accept_s;
        end else begin
          cnt_s      = cnt_r + CNT_ONE;
          fill_shd_s = accept_s;
        end
      end
      ST_FINISH: begin
        state_s     = ST_IDLE;
        cnt_s       = CNT_ZERO;
        apply_shd_s = shd_full_r;
        load_cfg_s  = accept_s;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    // Shadow apply wins; a new offer is only accepted while the shadow is empty.
    if (apply_shd_s) begin
      div_s      = shd_div_r;
      burst_s    = shd_burst_r;
      remain_s   = shd_burst_r;
      shd_full_s = 1'b0;
    end else if (load_cfg_s) begin
      div_s      = clamp_div(cfg_div);
      burst_s    = cfg_burst;
      remain_s   = cfg_burst;
    end else if (fill_shd_s) begin
      shd_full_s  = 1'b1;
      shd_div_s   = clamp_div(cfg_div);
      shd_burst_s = cfg_burst;
    end else begin
      shd_full_s  = shd_full_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      div_r       <= DIV_RST;
      burst_r     <= BURST_ZERO;
      remain_r    <= BURST_ZERO;
      shd_full_r  <= 1'b0;
      shd_div_r   <= DIV_RST;
      shd_burst_r <= BURST_ZERO;
      tick_r      <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      div_r       <= div_s;
      burst_r     <= burst_s;
      remain_r    <= remain_s;
      shd_full_r  <= shd_full_s;
      shd_div_r   <= shd_div_s;
      shd_burst_r <= shd_burst_s;
      tick_r      <= tick_s;
      done_r      <= done_s;
      busy_r      <= (state_s != ST_IDLE);
      ready_r     <= !shd_full_s;
    end
  end

  assign tick      = tick_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign cfg_ready = ready_r;
  assign div_cur   = div_r;

`ifdef CLKDIV_CTRL_TICK_CNT_EN
  logic [31:0] tick_cnt_r;

  // Saturating count of issued ticks, cleared when a run starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      tick_cnt_r <= 32'd0;
    end else if (tick_s && (tick_cnt_r != 32'hFFFF_FFFF)) begin
      tick_cnt_r <= tick_cnt_r + 32'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  assign tick_count = tick_cnt_r;
`endif

endmodule
